// File: rtl/axil_reg_responder.sv
// +----------------------------------------------------------------------------+
// | axil_reg_responder                                                         |
// | AXI4-Lite slave holding NREGS control registers with per-register strobes. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module axil_reg_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NREGS      = 8
) (
  input  logic                        clk,
  input  logic                        resn,
  input  logic [ADDR_WIDTH-1:0]       aw_addr,
  input  logic                        aw_valid,
  output logic                        aw_ready,
  input  logic [DATA_WIDTH-1:0]       w_data,
  input  logic [DATA_WIDTH/8-1:0]     w_strb,
  input  logic                        w_valid,
  output logic                        w_ready,
  output logic                        b_valid,
  input  logic                        b_ready,
  input  logic [ADDR_WIDTH-1:0]       ar_addr,
  input  logic                        ar_valid,
  output logic                        ar_ready,
  output logic [DATA_WIDTH-1:0]       r_data,
  output logic                        r_valid,
  input  logic                        r_ready,
  output logic [NREGS*DATA_WIDTH-1:0] reg_o,
  output logic [NREGS-1:0]            wr_pulse
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int SW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ACK  = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ACK  = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  w_state_t              w_state_q, w_state_d;
  logic                  aw_rdy_q, aw_rdy_d;
  logic                  b_valid_q, b_valid_d;
  logic [NREGS-1:0]      wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NREGS];
  logic [DATA_WIDTH-1:0] regs_d [NREGS];

  r_state_t              r_state_q, r_state_d;
  logic                  ar_rdy_q, ar_rdy_d;
  logic                  r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;

  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;
  logic          unused_addr_bits;

  assign w_idx            = aw_addr[ADDR_WIDTH-1:2];
  assign r_idx            = ar_addr[ADDR_WIDTH-1:2];
  assign unused_addr_bits = ^{aw_addr[1:0], ar_addr[1:0]};

  // W_ACK spends one cycle raising the readies and commits on the edge where they are high.
  always_comb begin
    w_state_d  = w_state_q;
    aw_rdy_d   = 1'b0;
    b_valid_d  = b_valid_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_valid && w_valid) w_state_d = W_ACK;
      end
      W_ACK: begin
        if (!aw_rdy_q) begin
          aw_rdy_d = 1'b1;
        end else begin
          w_state_d = W_RESP;
          b_valid_d = 1'b1;
          // Out-of-range indices match no k, so they commit nothing and raise no strobe.
          for (int k = 0; k < NREGS; k++) begin
            if (w_idx == IW'(k)) begin
              wr_pulse_d[k] = 1'b1;
              for (int b = 0; b < SW; b++) begin
                if (w_strb[b]) regs_d[k][b*8 +: 8] = w_data[b*8 +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (b_ready) begin
          b_valid_d = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_rdy_d  = 1'b0;
    r_valid_d = r_valid_q;
    r_data_d  = r_data_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_valid) r_state_d = R_ACK;
      end
      R_ACK: begin
        if (!ar_rdy_q) begin
          ar_rdy_d = 1'b1;
        end else begin
          r_state_d = R_DATA;
          r_valid_d = 1'b1;
          r_data_d  = '0;
          // Sampling regs_q gives the pre-write value when a write commits on the same edge.
          for (int k = 0; k < NREGS; k++) begin
            if (r_idx == IW'(k)) r_data_d = regs_q[k];
          end
        end
      end
      R_DATA: begin
        if (r_ready) begin
          r_valid_d = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      w_state_q  <= W_IDLE;
      aw_rdy_q   <= 1'b0;
      b_valid_q  <= 1'b0;
      wr_pulse_q <= '0;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
      r_state_q  <= R_IDLE;
      ar_rdy_q   <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_rdy_q   <= aw_rdy_d;
      b_valid_q  <= b_valid_d;
      wr_pulse_q <= wr_pulse_d;
      for (int k = 0; k < NREGS; k++) regs_q[k] <= regs_d[k];
      r_state_q  <= r_state_d;
      ar_rdy_q   <= ar_rdy_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
    end
  end

  assign aw_ready = aw_rdy_q;
  assign w_ready  = aw_rdy_q;
  assign b_valid  = b_valid_q;
  assign wr_pulse = wr_pulse_q;
  assign ar_ready = ar_rdy_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;

  generate
    for (genvar g = 0; g < NREGS; g++) begin : g_flat
      assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_axil_reg_responder.sv
// +----------------------------------------------------------------------------+
// | tb_axil_reg_responder                                                      |
// | Self-checking bench: vector table, hand sequences and random traffic.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_axil_reg_responder;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NR = 8;

  logic           clk = 1'b0;
  logic           resn;
  logic [AW-1:0]  aw_addr, ar_addr;
  logic           aw_valid, w_valid, b_ready, ar_valid, r_ready;
  logic [DW-1:0]  w_data;
  logic [3:0]     w_strb;
  logic           aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [DW-1:0]  r_data;
  logic [NR*DW-1:0] reg_o;
  logic [NR-1:0]  wr_pulse;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [NR];

  always #5 clk = ~clk;

  axil_reg_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREGS(NR)) dut (
    .clk(clk), .resn(resn),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
    .reg_o(reg_o), .wr_pulse(wr_pulse)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] rd_exp;
  } vec_t;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] reg_of(input int k);
    return reg_o[k*DW +: DW];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] exp_read(input logic [7:0] a);
    int idx;
    idx = int'(a) / 4;
    return (idx < NR) ? model[idx] : 32'h0;
  endfunction

  task automatic check_regs(input string tag);
    for (int k = 0; k < NR; k++) check(tag, {k[31:0], reg_of(k)}, {k[31:0], model[k]});
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    int idx;
    logic [NR-1:0] exp_pulse;
    idx = int'(a) / 4;
    exp_pulse = '0;
    if (idx < NR) exp_pulse[idx] = 1'b1;
    aw_addr = a; w_data = d; w_strb = s; aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!aw_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr_ready_timeout", n < 20, 1);
    check("wr_readies_together", w_ready, aw_ready);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    check("b_valid_after_hs", b_valid, 1);
    check("wr_pulse_after_hs", wr_pulse, exp_pulse);
    if (idx < NR) model[idx] = merge(model[idx], d, s);
    check_regs("reg_o_after_write");
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("b_valid_cleared", b_valid, 0);
    check("wr_pulse_one_cycle", wr_pulse, 0);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp, input int stall);
    int n;
    ar_addr = a; ar_valid = 1'b1; r_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!ar_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_ready_timeout", n < 20, 1);
    @(negedge clk);
    ar_valid = 1'b0;
    check("r_valid_after_hs", r_valid, 1);
    check("r_data", r_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("r_valid_stall", r_valid, 1);
      check("r_data_stall", r_data, exp);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check("r_valid_cleared", r_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [7];
    logic [31:0] old;
    int n;
    vecs[0] = '{8'h04, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D};
    vecs[1] = '{8'h04, 32'h11223344, 4'h3, 32'hCAFE3344};
    vecs[2] = '{8'h08, 32'hA5A5A5A5, 4'hA, 32'hA500A500};
    vecs[3] = '{8'h1F, 32'h12345678, 4'hF, 32'h12345678};
    vecs[4] = '{8'h1C, 32'hFFFFFFFF, 4'h1, 32'h123456FF};
    vecs[5] = '{8'h40, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[6] = '{8'h01, 32'hDEADBEEF, 4'hC, 32'hDEAD0000};

    resn = 1'b0;
    aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
    aw_valid = 1'b0; w_valid = 1'b0; b_ready = 1'b0; ar_valid = 1'b0; r_ready = 1'b0;
    for (int k = 0; k < NR; k++) model[k] = '0;

    repeat (3) @(negedge clk);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_ar_ready", ar_ready, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_o_zero", reg_o == '0, 1);
    resn = 1'b1;
    @(negedge clk);

    // Reset while a write response is pending.
    aw_addr = 8'h04; w_data = 32'h55AA55AA; w_strb = 4'hF;
    aw_valid = 1'b1; w_valid = 1'b1; b_ready = 1'b0;
    n = 0;
    while (!b_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_b_valid", b_valid, 1);
    check("pre_rst_reg1", reg_of(1), 32'h55AA55AA);
    aw_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    resn = 1'b0;
    #1;
    check("midrst_b_valid", b_valid, 0);
    check("midrst_aw_ready", aw_ready, 0);
    check("midrst_reg_o_zero", reg_o == '0, 1);
    repeat (2) @(negedge clk);
    resn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_b_valid", b_valid, 0);
      check("post_rst_aw_ready", aw_ready, 0);
    end

    for (int v = 0; v < 7; v++) begin
      do_write(vecs[v].addr, vecs[v].data, vecs[v].strb);
      do_read(vecs[v].addr, vecs[v].rd_exp, 0);
    end

    // Stalled read while an unrelated write completes.
    old = exp_read(8'h04);
    fork
      do_read(8'h04, old, 4);
      begin
        repeat (2) @(negedge clk);
        do_write(8'h08, 32'h0F0F0F0F, 4'hF);
      end
    join
    do_read(8'h08, 32'h0F0F0F0F, 0);

    // AW without W must not be accepted.
    @(negedge clk);
    aw_addr = 8'h14; aw_valid = 1'b1; w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_alone_ready", {aw_ready, w_ready}, 2'b00);
    end
    w_data = 32'h76543210; w_strb = 4'hF; w_valid = 1'b1;
    @(negedge clk);
    check("aw_w_ready_lat1", {aw_ready, w_ready}, 2'b00);
    @(negedge clk);
    check("aw_w_ready_lat2", {aw_ready, w_ready}, 2'b11);
    @(negedge clk);
    aw_valid = 1'b0; w_valid = 1'b0;
    check("aw_w_ready_once", {aw_ready, w_ready}, 2'b00);
    check("aw_w_b_valid", b_valid, 1);
    check("aw_w_pulse", wr_pulse, 8'h20);
    model[5] = 32'h76543210;
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    check("aw_w_b_done", b_valid, 0);

    // Read and write of the same register on the same edge.
    old = exp_read(8'h0C);
    fork
      do_read(8'h0C, old, 0);
      do_write(8'h0C, 32'h0BADF00D, 4'hF);
    join
    do_read(8'h0C, 32'h0BADF00D, 0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(1, 15)));
      else
        do_read(a, exp_read(a), int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
